// File: rtl/collision_pkg.sv
// Shared definitions for the collision-engine arbiter: sequencer states and
// default sizing constants.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_e;

    localparam int POSITION_SIZE_DEFAULT  = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: scans the request vector starting at rr_ptr_i and
// returns the first requesting node (rotate-and-priority-encode).
module rr_picker #(
    parameter int NUM_NODES = 4,
    parameter int ID_W      = $clog2(NUM_NODES)
) (
    input  logic [NUM_NODES-1:0] req_i,
    input  logic [ID_W-1:0]      rr_ptr_i,
    output logic                 valid_o,
    output logic [ID_W-1:0]      id_o
);

    int   idx_s;
    logic hit_s;

    // Walk the nodes in rotated order; the first hit wins and later hits are masked
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            idx_s   = (int'(rr_ptr_i) + i) % NUM_NODES;
            hit_s   = req_i[idx_s] & ~valid_o;
            valid_o = valid_o | hit_s;
            id_o    = hit_s ? ID_W'(idx_s) : id_o;
        end
    end

endmodule

// File: rtl/collision_arbiter.sv
// collision_arbiter: shares one obstacle-sweep engine among NUM_NODES mass
// points. Grants round-robin, latches the winner's operands, runs the engine
// begin/done handshake and returns the resolved position tagged with the id.
// Optional build macro COLL_ARB_WATCHDOG_EN adds an engine-wait watchdog that
// aborts after TIMEOUT_CYCLES wait cycles and returns the original position.
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int NUM_NODES      = 4,
    parameter int POSITION_SIZE  = POSITION_SIZE_DEFAULT,
    parameter int ID_W           = $clog2(NUM_NODES),
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_NODES-1:0]               req_in,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] pos_x_in,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] pos_y_in,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] dx_in,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] dy_in,
    output logic [NUM_NODES-1:0]               grant_out,
    output logic                               done_out,
    output logic [ID_W-1:0]                    done_id_out,
    output logic [POSITION_SIZE-1:0]           x_new_out,
    output logic [POSITION_SIZE-1:0]           y_new_out,
    output logic                               timeout_out,
    output logic                               busy_out,
    output logic                               eng_begin_out,
    output logic [POSITION_SIZE-1:0]           eng_pos_x_out,
    output logic [POSITION_SIZE-1:0]           eng_pos_y_out,
    output logic [POSITION_SIZE-1:0]           eng_dx_out,
    output logic [POSITION_SIZE-1:0]           eng_dy_out,
    input  logic                               eng_done_in,
    input  logic [POSITION_SIZE-1:0]           eng_x_new_in,
    input  logic [POSITION_SIZE-1:0]           eng_y_new_in,
    output logic [15:0]                        service_count_out
);

    state_e                   state_q;
    logic [ID_W-1:0]          rr_ptr_q;
    logic [ID_W-1:0]          id_q;
    logic [NUM_NODES-1:0]     grant_q;
    logic                     eng_begin_q;
    logic                     done_q;
    logic                     busy_q;
    logic [ID_W-1:0]          done_id_q;
    logic [POSITION_SIZE-1:0] op_x_q, op_y_q, op_dx_q, op_dy_q;
    logic [POSITION_SIZE-1:0] res_x_q, res_y_q;
    logic [POSITION_SIZE-1:0] x_new_q, y_new_q;
    logic [15:0]              count_q;

    logic                     pick_valid_s;
    logic [ID_W-1:0]          pick_id_s;
    logic [NUM_NODES-1:0]     grant_d;
    logic [ID_W-1:0]          rr_ptr_d;
    logic [POSITION_SIZE-1:0] sel_x_s, sel_y_s, sel_dx_s, sel_dy_s;

`ifdef COLL_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             res_to_q;
    logic             timeout_q;
`endif

    rr_picker #(
        .NUM_NODES (NUM_NODES),
        .ID_W      (ID_W)
    ) u_picker (
        .req_i     (req_in),
        .rr_ptr_i  (rr_ptr_q),
        .valid_o   (pick_valid_s),
        .id_o      (pick_id_s)
    );

    // Operand mux for the candidate winner, its one-hot grant and the next pointer
    always_comb begin
        sel_x_s  = pos_x_in[int'(pick_id_s)*POSITION_SIZE +: POSITION_SIZE];
        sel_y_s  = pos_y_in[int'(pick_id_s)*POSITION_SIZE +: POSITION_SIZE];
        sel_dx_s = dx_in[int'(pick_id_s)*POSITION_SIZE +: POSITION_SIZE];
        sel_dy_s = dy_in[int'(pick_id_s)*POSITION_SIZE +: POSITION_SIZE];
        grant_d  = '0;
        grant_d[pick_id_s] = pick_valid_s;
        if (id_q == ID_W'(NUM_NODES - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = id_q + ID_W'(1);
        end
    end

    // Transaction sequencer with all handshake and result outputs registered
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            grant_q     <= '0;
            eng_begin_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_id_q   <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_dx_q     <= '0;
            op_dy_q     <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            x_new_q     <= '0;
            y_new_q     <= '0;
            count_q     <= 16'd0;
`ifdef COLL_ARB_WATCHDOG_EN
            wait_cnt_q  <= '0;
            res_to_q    <= 1'b0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            grant_q     <= '0;
            eng_begin_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef COLL_ARB_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        id_q    <= pick_id_s;
                        grant_q <= grant_d;
                        op_x_q  <= sel_x_s;
                        op_y_q  <= sel_y_s;
                        op_dx_q <= sel_dx_s;
                        op_dy_q <= sel_dy_s;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    eng_begin_q <= 1'b1;
`ifdef COLL_ARB_WATCHDOG_EN
                    wait_cnt_q  <= '0;
`endif
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A real result on the timeout cycle takes priority over the abort
                    if (eng_done_in) begin
                        res_x_q  <= eng_x_new_in;
                        res_y_q  <= eng_y_new_in;
`ifdef COLL_ARB_WATCHDOG_EN
                        res_to_q <= 1'b0;
`endif
                        state_q  <= RESPOND;
`ifdef COLL_ARB_WATCHDOG_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_x_q  <= op_x_q;
                        res_y_q  <= op_y_q;
                        res_to_q <= 1'b1;
                        state_q  <= RESPOND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        state_q    <= WAIT;
                    end
`else
                    end else begin
                        state_q  <= WAIT;
                    end
`endif
                end
                RESPOND: begin
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    x_new_q   <= res_x_q;
                    y_new_q   <= res_y_q;
`ifdef COLL_ARB_WATCHDOG_EN
                    timeout_q <= res_to_q;
`endif
                    rr_ptr_q  <= rr_ptr_d;
                    count_q   <= count_q + 16'd1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_out         = grant_q;
    assign done_out          = done_q;
    assign done_id_out       = done_id_q;
    assign x_new_out         = x_new_q;
    assign y_new_out         = y_new_q;
    assign busy_out          = busy_q;
    assign eng_begin_out     = eng_begin_q;
    assign eng_pos_x_out     = op_x_q;
    assign eng_pos_y_out     = op_y_q;
    assign eng_dx_out        = op_dx_q;
    assign eng_dy_out        = op_dy_q;
    assign service_count_out = count_q;
`ifdef COLL_ARB_WATCHDOG_EN
    assign timeout_out       = timeout_q;
`else
    assign timeout_out       = 1'b0;
`endif

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter (default build). A transaction-level
// reference model predicts grants, engine-wait lengths and result timing; a
// separate monitor pops expected results whenever done_out is presented.
module tb_collision_arbiter;

    localparam int N  = 4;
    localparam int PS = 8;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req_in;
    logic [N*PS-1:0] pos_x_in, pos_y_in, dx_in, dy_in;
    logic [N-1:0]    grant_out;
    logic            done_out;
    logic [1:0]      done_id_out;
    logic [PS-1:0]   x_new_out, y_new_out;
    logic            timeout_out, busy_out, eng_begin_out;
    logic [PS-1:0]   eng_pos_x_out, eng_pos_y_out, eng_dx_out, eng_dy_out;
    logic            eng_done_in;
    logic [PS-1:0]   eng_x_new_in, eng_y_new_in;
    logic [15:0]     service_count_out;

    collision_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .dx_in(dx_in), .dy_in(dy_in),
        .grant_out(grant_out), .done_out(done_out), .done_id_out(done_id_out),
        .x_new_out(x_new_out), .y_new_out(y_new_out), .timeout_out(timeout_out),
        .busy_out(busy_out), .eng_begin_out(eng_begin_out),
        .eng_pos_x_out(eng_pos_x_out), .eng_pos_y_out(eng_pos_y_out),
        .eng_dx_out(eng_dx_out), .eng_dy_out(eng_dy_out),
        .eng_done_in(eng_done_in), .eng_x_new_in(eng_x_new_in),
        .eng_y_new_in(eng_y_new_in), .service_count_out(service_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         id;
        logic [7:0] x;
        logic [7:0] y;
        int         edge_no;
        int         cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         e_q[$];
    int         rec[$];
    int         total = 0;
    int         bad   = 0;
    int         edge_cnt;
    int         m_ptr, free_edge, last_g, m_cnt, force_e;
    bit         clear_next[N];
    bit         just[N];
    logic [7:0] ox[N], oy[N], odx[N], ody[N];
    logic [N-1:0] req_r;
    bit         rand_en = 1'b0, spur_en = 1'b0, no_resp = 1'b0, always_raise = 1'b0;

    // Edge counter shared by the model and the monitor
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_in[k]          = req_r[k];
            pos_x_in[k*PS+:PS] = ox[k];
            pos_y_in[k*PS+:PS] = oy[k];
            dx_in[k*PS+:PS]    = odx[k];
            dy_in[k*PS+:PS]    = ody[k];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; free_edge = 0; last_g = -100; m_cnt = 0;
        sb_q.delete(); e_q.delete();
        req_r = '0;
        for (int k = 0; k < N; k++) clear_next[k] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, grant_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_id"}, done_id_out, 0);
        chk({tag, "_x"}, x_new_out, 0);
        chk({tag, "_y"}, y_new_out, 0);
        chk({tag, "_timeout"}, timeout_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_begin"}, eng_begin_out, 0);
        chk({tag, "_engops"}, {eng_pos_x_out, eng_pos_y_out, eng_dx_out, eng_dy_out}, 0);
        chk({tag, "_count"}, service_count_out, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        drive();
        #1;
        chk_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // One clock of stimulus plus the reference model's prediction for the coming edge
    task automatic step();
        int         upc, gid, e;
        logic [N-1:0] eg;
        logic [7:0] ex, ey;
        @(negedge clk_in);
        for (int k = 0; k < N; k++) begin
            just[k] = clear_next[k];
            if (clear_next[k]) begin
                req_r[k] = 1'b0;
                clear_next[k] = 1'b0;
            end
        end
        if (rand_en) begin
            for (int k = 0; k < N; k++) begin
                if (!just[k]) begin
                    if (!req_r[k]) begin
                        if (always_raise || $urandom_range(0, 2) == 0) begin
                            req_r[k] = 1'b1;
                            ox[k] = 8'($urandom); oy[k] = 8'($urandom);
                            odx[k] = 8'($urandom); ody[k] = 8'($urandom);
                        end
                    end else if (!always_raise && $urandom_range(0, 19) == 0) begin
                        req_r[k] = 1'b0;
                    end
                end
            end
        end
        drive();
        upc = edge_cnt + 1;
        eg  = '0;
        if (upc >= free_edge && req_r != '0) begin
            gid = -1;
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (gid < 0 && req_r[j]) gid = j;
            end
            e = (force_e > 0) ? force_e : int'($urandom_range(1, 6));
            e_q.push_back(e);
            m_cnt++;
            ex = ox[gid] + odx[gid];
            ey = oy[gid] + ody[gid];
            sb_q.push_back('{gid, ex, ey, upc + e + 3, m_cnt});
            free_edge = upc + e + 4;
            last_g    = upc;
            m_ptr     = (gid + 1) % N;
            clear_next[gid] = 1'b1;
            eg[gid] = 1'b1;
        end
        @(posedge clk_in);
        #1;
        chk("grant", grant_out, eg);
        chk("busy", busy_out, (edge_cnt >= last_g && edge_cnt <= free_edge - 2));
        chk("begin", eng_begin_out, (edge_cnt == last_g + 1));
        for (int i = 0; i < N; i++) if (grant_out[i]) rec.push_back(i);
    endtask

    task automatic drain();
        rand_en = 1'b0;
        req_r = '0;
        for (int i = 0; i < 100; i++) if (sb_q.size() != 0) step();
        chk("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: every presented result must match the oldest expected transaction
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_in);
            if (rst_in === 1'b0 && done_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done_out=1 id=%0d expected no result", done_id_out);
                end else begin
                    x = sb_q.pop_front();
                    chk("done_edge", edge_cnt, x.edge_no);
                    chk("done_id", done_id_out, x.id);
                    chk("x_new", x_new_out, x.x);
                    chk("y_new", y_new_out, x.y);
                    chk("timeout", timeout_out, 0);
                    chk("svc_count", service_count_out, x.cnt);
                end
            end
        end
    end

    // Engine model: answers begin after E cycles with pos+d; may emit stray done pulses
    initial begin
        int cnt;
        logic [7:0] ex, ey;
        cnt = 0; ex = 8'd0; ey = 8'd0;
        eng_done_in = 1'b0; eng_x_new_in = 8'd0; eng_y_new_in = 8'd0;
        forever begin
            @(negedge clk_in);
            if (eng_begin_out === 1'b1 && !no_resp) begin
                if (e_q.size() > 0) cnt = e_q.pop_front();
                else cnt = 1;
                ex = eng_pos_x_out + eng_dx_out;
                ey = eng_pos_y_out + eng_dy_out;
                eng_done_in = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done_in = 1'b1; eng_x_new_in = ex; eng_y_new_in = ey;
                end else begin
                    eng_done_in = 1'b0;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                eng_done_in = 1'b1;
                eng_x_new_in = 8'($urandom); eng_y_new_in = 8'($urandom);
            end else begin
                eng_done_in = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int exp_seq[5];
        int stuck_ok;
        rst_in = 1'b1;
        force_e = 0;
        for (int k = 0; k < N; k++) begin
            ox[k] = 8'd0; oy[k] = 8'd0; odx[k] = 8'd0; ody[k] = 8'd0;
        end
        model_reset();
        drive();
        do_reset();

        // Single request: node2 at (10,20) moving (3,-1), E=5
        force_e = 5;
        req_r[2] = 1'b1; ox[2] = 8'd10; oy[2] = 8'd20; odx[2] = 8'd3; ody[2] = 8'hFF;
        repeat (12) step();
        chk("single_x_hold", x_new_out, 13);
        chk("single_y_hold", y_new_out, 19);
        chk("single_id_hold", done_id_out, 2);
        chk("single_count", service_count_out, 1);
        drain();

        // Fairness: all four requesting continuously from pointer 0
        do_reset();
        force_e = 0;
        rec.delete();
        rand_en = 1'b1; always_raise = 1'b1;
        for (int i = 0; i < 200; i++) if (rec.size() < 5) step();
        always_raise = 1'b0;
        drain();
        exp_seq = '{0, 1, 2, 3, 0};
        chk("fair_len", (rec.size() >= 5), 1);
        if (rec.size() >= 5) for (int i = 0; i < 5; i++) chk("fair_order", rec[i], exp_seq[i]);

        // Wrap: serve node2 so the pointer sits at 3, then node3 and node0 together
        do_reset();
        rec.delete();
        force_e = 1;
        req_r[2] = 1'b1; ox[2] = 8'd1; oy[2] = 8'd2; odx[2] = 8'd3; ody[2] = 8'd4;
        repeat (8) step();
        req_r[3] = 1'b1; ox[3] = 8'd50; oy[3] = 8'd60; odx[3] = 8'd1; ody[3] = 8'd1;
        req_r[0] = 1'b1; ox[0] = 8'd70; oy[0] = 8'd80; odx[0] = 8'd2; ody[0] = 8'd2;
        repeat (14) step();
        drain();
        chk("wrap_len", rec.size(), 3);
        if (rec.size() == 3) begin
            chk("wrap_first", rec[0], 2);
            chk("wrap_second", rec[1], 3);
            chk("wrap_third", rec[2], 0);
        end

        // Random traffic with stray engine done pulses outside WAIT
        force_e = 0;
        rand_en = 1'b1; spur_en = 1'b1;
        repeat (600) step();
        spur_en = 1'b0;
        drain();

        // Reset two cycles after begin; the late engine done must be ignored
        do_reset();
        force_e = 5;
        req_r[1] = 1'b1; ox[1] = 8'd9; oy[1] = 8'd8; odx[1] = 8'd7; ody[1] = 8'd6;
        for (int i = 0; i < 10; i++) if (eng_begin_out !== 1'b1) step();
        chk("rst_wait_begin_seen", eng_begin_out, 1);
        repeat (2) step();
        #2;
        rst_in = 1'b1;
        #1;
        chk_zero("midwait");
        model_reset();
        drive();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (10) step();
        chk("midwait_count", service_count_out, 0);
        chk("midwait_done", done_out, 0);
        force_e = 0;

`ifndef COLL_ARB_WATCHDOG_EN
        // Silent engine: without the watchdog the arbiter waits indefinitely
        no_resp = 1'b1;
        @(negedge clk_in);
        req_r = 4'b0001; drive();
        @(negedge clk_in);
        req_r = 4'b0000; drive();
        stuck_ok = 1;
        repeat (200) begin
            @(negedge clk_in);
            if (busy_out !== 1'b1 || done_out !== 1'b0) stuck_ok = 0;
        end
        chk("stuck_busy", stuck_ok, 1);
        no_resp = 1'b0;
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
